// File: rtl/wb_pkg.sv
// Shared defaults and types for the writeback arbiter and its LSU result buffer.
package wb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned AW_DEFAULT    = 5;
  localparam int unsigned DW_DEFAULT    = 32;

  // Writes to the zero register are architecturally discarded.
  localparam int unsigned X0 = 0;

  typedef struct packed {
    logic                  live;
    logic [AW_DEFAULT-1:0] rd;
    logic [DW_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_buffer.sv
// LSU result FIFO with kill-by-destination and live rd-match lookups for hazard reporting.
module wb_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_rd,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          kill_en,
  input  logic [AW-1:0] kill_rd,
  output logic          empty,
  output logic          full,
  output logic          head_live,
  output logic [AW-1:0] head_rd,
  output logic [DW-1:0] head_data,
  input  logic [AW-1:0] match_a_addr,
  input  logic [AW-1:0] match_b_addr,
  output logic          match_a,
  output logic          match_b
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign head_live = live_q[rd_ptr_q];
  assign head_rd   = rd_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  always_comb begin
    live_d   = live_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    if (kill_en) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (rd_q[i] == kill_rd) begin
          live_d[i] = 1'b0;
        end
      end
    end
    // Popped slots are cleared so stale live bits never feed the hazard lookup.
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end
    if (push) begin
      live_d[wr_ptr_q] = !(kill_en && (push_rd == kill_rd));
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
  end

  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (live_q[i] && (rd_q[i] == match_a_addr)) begin
        match_a = 1'b1;
      end
      if (live_q[i] && (rd_q[i] == match_b_addr)) begin
        match_b = 1'b1;
      end
    end
    if (match_a_addr == AW'(X0)) begin
      match_a = 1'b0;
    end
    if (match_b_addr == AW'(X0)) begin
      match_b = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset; validity is carried entirely by live_q and count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= push_rd;
      data_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: ALU results win, LSU results queue behind them in order.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_pending,
  output logic          rs2_pending,
  output logic          RegWrite,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] write_data
);

  logic          alu_issue, head_issue, pop, push;
  logic          fifo_empty, fifo_full;
  logic          head_live;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;
  logic          buf_match_1, buf_match_2;

  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] write_data_q, write_data_d;

  assign lsu_ready = !reset && !fifo_full;
  assign push      = lsu_valid && lsu_ready;

  wb_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_rd      (lsu_rd),
    .push_data    (lsu_data),
    .pop          (pop),
    .kill_en      (alu_issue),
    .kill_rd      (alu_rd),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .head_live    (head_live),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .match_a_addr (rs1_addr),
    .match_b_addr (rs2_addr),
    .match_a      (buf_match_1),
    .match_b      (buf_match_2)
  );

  // An x0 ALU result counts as idle so the buffer can drain in that slot.
  always_comb begin
    alu_issue    = alu_valid && (alu_rd != AW'(X0));
    pop          = !alu_issue && !fifo_empty;
    head_issue   = pop && head_live && (head_rd != AW'(X0));
    reg_write_d  = 1'b0;
    rd_addr_d    = '0;
    write_data_d = '0;
    if (alu_issue) begin
      reg_write_d  = 1'b1;
      rd_addr_d    = alu_rd;
      write_data_d = alu_data;
    end else if (head_issue) begin
      reg_write_d  = 1'b1;
      rd_addr_d    = head_rd;
      write_data_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      rd_addr_q    <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      rd_addr_q    <= rd_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite   = reg_write_q;
  assign rd_addr    = rd_addr_q;
  assign write_data = write_data_q;

  assign rs1_pending = buf_match_1 ||
                       (reg_write_q && (rd_addr_q == rs1_addr) && (rs1_addr != AW'(X0)));
  assign rs2_pending = buf_match_2 ||
                       (reg_write_q && (rd_addr_q == rs2_addr) && (rs2_addr != AW'(X0)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue-based reference model checked every cycle plus literal checks.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, lsu_valid, lsu_ready;
  logic [AW-1:0] alu_rd, lsu_rd, rs1_addr, rs2_addr, rd_addr;
  logic [DW-1:0] alu_data, lsu_data, write_data;
  logic          rs1_pending, rs2_pending, RegWrite;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .RegWrite    (RegWrite),
    .rd_addr     (rd_addr),
    .write_data  (write_data)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: ordered list of buffered results plus the expected write-port register.
  wb_entry_t     mq[$];
  logic          m_we   = 1'b0;
  logic [AW-1:0] m_rd   = '0;
  logic [DW-1:0] m_data = '0;
  bit            model_ok = 1'b0;

  function automatic bit pend(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_we && m_rd == a) return 1'b1;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  // Inputs change just after posedge, so at negedge they equal what the next edge samples.
  initial begin
    bit        alu_hit, acc;
    wb_entry_t h;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("cmp_regwrite", RegWrite, m_we);
        check("cmp_rd_addr", rd_addr, m_rd);
        check("cmp_write_data", write_data, m_data);
        check("cmp_lsu_ready", lsu_ready, !reset && mq.size() < DEPTH);
        check("cmp_rs1_pending", rs1_pending, pend(rs1_addr));
        check("cmp_rs2_pending", rs2_pending, pend(rs2_addr));
      end
      if (reset) begin
        mq.delete();
        m_we = 1'b0; m_rd = '0; m_data = '0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        alu_hit = alu_valid && alu_rd != 0;
        acc     = lsu_valid && mq.size() < DEPTH;
        m_we = 1'b0; m_rd = '0; m_data = '0;
        if (alu_hit) begin
          m_we = 1'b1; m_rd = alu_rd; m_data = alu_data;
          foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
        end else if (mq.size() > 0) begin
          h = mq.pop_front();
          if (h.live && h.rd != 0) begin
            m_we = 1'b1; m_rd = h.rd; m_data = h.data;
          end
        end
        if (acc) begin
          h.live = !(alu_hit && lsu_rd == alu_rd);
          h.rd   = lsu_rd;
          h.data = lsu_data;
          mq.push_back(h);
        end
      end
    end
  end

  // Log of everything the DUT writes to the register file.
  logic [AW-1:0] wlog_rd[$];
  logic [DW-1:0] wlog_data[$];
  initial begin
    forever begin
      @(negedge clk);
      if (RegWrite === 1'b1) begin
        wlog_rd.push_back(rd_addr);
        wlog_data.push_back(write_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  task automatic clear_log();
    wlog_rd.delete();
    wlog_data.delete();
  endtask

  int t2_rd [12] = '{1, 2, 3, 4, 5, 6, 10, 11, 12, 13, 14, 15};
  int t2_dat[12] = '{'h100, 'h101, 'h102, 'h103, 'h104, 'h105,
                     'h200, 'h201, 'h202, 'h203, 'h204, 'h205};

  initial begin
    int acc;
    bit rdy;
    int n7;
    logic [DW-1:0] d7;

    reset = 1'b1; idle();
    alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_regwrite", RegWrite, 1'b0);
    check("reset_rd_addr", rd_addr, 0);
    check("first_cycle_ready", lsu_ready, 1'b1);

    // T1: single ALU write lands exactly one cycle later
    tick();
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    check("model_t1_we", m_we, 1'b1);
    check("model_t1_rd", m_rd, 5);
    idle();
    @(negedge clk);
    check("t1_regwrite", RegWrite, 1'b1);
    check("t1_rd_addr", rd_addr, 5);
    check("t1_data", write_data, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("t1_one_cycle_only", RegWrite, 1'b0);

    // T2: ALU burst starves and fills the buffer; order must be preserved afterwards
    tick();
    clear_log();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = AW'(i + 1); alu_data = DW'(32'h100 + i);
      lsu_valid = 1'b1; lsu_rd = AW'(10 + acc); lsu_data = DW'(32'h200 + acc);
      @(negedge clk);
      rdy = lsu_ready;
      tick();
      if (rdy) acc++;
    end
    check("t2_accepts_during_burst", acc, 4);
    alu_valid = 1'b0;
    @(negedge clk);
    check("t2_full_ready_low", lsu_ready, 1'b0);
    for (int g = 0; g < 20 && acc < 6; g++) begin
      lsu_rd = AW'(10 + acc); lsu_data = DW'(32'h200 + acc);
      @(negedge clk);
      rdy = lsu_ready;
      tick();
      if (rdy) acc++;
    end
    check("t2_all_accepted", acc, 6);
    idle();
    repeat (8) tick();
    check("t2_write_count", wlog_rd.size(), 12);
    for (int i = 0; i < wlog_rd.size() && i < 12; i++) begin
      check("t2_order_rd", wlog_rd[i], t2_rd[i]);
      check("t2_order_data", wlog_data[i], t2_dat[i]);
    end

    // T3: WAW kill of a buffered load by a younger ALU write
    clear_log();
    alu_valid = 1'b1; alu_rd = 3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 7; lsu_data = 32'h11;
    tick();
    lsu_valid = 1'b0; alu_rd = 7; alu_data = 32'h22;
    tick();
    idle();
    @(negedge clk);
    check("t3_alu_rd7", rd_addr, 7);
    tick();
    @(negedge clk);
    check("t3_killed_pop_silent", RegWrite, 1'b0);
    repeat (3) tick();
    n7 = 0; d7 = '0;
    foreach (wlog_rd[i]) if (wlog_rd[i] == 7) begin n7++; d7 = wlog_data[i]; end
    check("t3_r7_write_count", n7, 1);
    check("t3_r7_data", d7, 32'h22);

    // T4: x0 destinations never write and never report pending
    clear_log();
    alu_valid = 1'b1; alu_rd = 0; alu_data = 32'hAA;
    lsu_valid = 1'b1; lsu_rd = 0; lsu_data = 32'hFF;
    rs1_addr = 0;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_no_regwrite", RegWrite, 1'b0);
      check("t4_rs1_pending_x0", rs1_pending, 1'b0);
      tick();
    end
    check("t4_log_empty", wlog_rd.size(), 0);

    // T5: pending tracks the buffered load through the output stage
    rs1_addr = 8; rs2_addr = 9;
    alu_valid = 1'b1; alu_rd = 4; alu_data = 32'h44;
    lsu_valid = 1'b1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    lsu_valid = 1'b0;
    @(negedge clk);
    check("t5_rs2_buffered", rs2_pending, 1'b1);
    check("t5_rs1_clear", rs1_pending, 1'b0);
    tick();
    idle();
    @(negedge clk);
    check("t5_rs2_still_buffered", rs2_pending, 1'b1);
    tick();
    @(negedge clk);
    check("t5_write_r9", RegWrite, 1'b1);
    check("t5_write_r9_addr", rd_addr, 9);
    check("t5_write_r9_data", write_data, 32'h99);
    check("t5_rs2_output_stage", rs2_pending, 1'b1);
    tick();
    @(negedge clk);
    check("t5_rs2_released", rs2_pending, 1'b0);
    check("t5_rs1_never", rs1_pending, 1'b0);

    // T6: reset discards three buffered results
    tick();
    rs1_addr = 20; rs2_addr = 0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 1; alu_data = DW'(32'h500 + i);
      lsu_valid = 1'b1; lsu_rd = AW'(20 + i); lsu_data = DW'(32'h300 + i);
      tick();
    end
    lsu_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t6_ready_low_in_reset", lsu_ready, 1'b0);
    check("t6_pending_before_reset", rs1_pending, 1'b1);
    tick();
    reset = 1'b0;
    idle();
    clear_log();
    @(negedge clk);
    check("t6_regwrite_zero", RegWrite, 1'b0);
    check("t6_rd_addr_zero", rd_addr, 0);
    check("t6_data_zero", write_data, 0);
    check("t6_ready_after_reset", lsu_ready, 1'b1);
    check("t6_pending_cleared", rs1_pending, 1'b0);
    repeat (6) tick();
    check("t6_no_writes_after_reset", wlog_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
